// File: rtl/master_bus_pkg.sv
// master_bus_pkg
//  Shared definitions for the master side of the serial system bus:
//  request instruction encodings, the receive-port state enum and a
//  helper that classifies an instruction as a read.
package master_bus_pkg;

  // Request types carried on the 2-bit instruction field.
  localparam logic [1:0] INSTR_RD_SINGLE = 2'b00;
  localparam logic [1:0] INSTR_RD_BURST  = 2'b01;
  localparam logic [1:0] INSTR_WR_SINGLE = 2'b10;
  localparam logic [1:0] INSTR_WR_BURST  = 2'b11;

  // Receive port states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } rx_state_t;

  // Only read requests cause the slave to send data back to the master.
  function automatic logic is_read(input logic [1:0] instr);
    return (instr == INSTR_RD_SINGLE) || (instr == INSTR_RD_BURST);
  endfunction

endpackage

// File: rtl/master_rx_shift.sv
// master_rx_shift
//  Serial-to-parallel deserializer for one data_len-bit word.
//  A bit is taken on every clock where shift_en is high. On the clock
//  that takes the last bit of a word, word_complete is high and word
//  presents the fully assembled value (including the bit being taken),
//  so the parent can register it on that same edge. The bit counter
//  wraps to 0 on that edge, so back-to-back words need no idle cycle.
//
//  Bit order: LSB first by default; MSB first when the macro
//  MASTER_IN_MSB_FIRST_EN is defined.
//
//  Ports
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   clear          in   restart at bit 0 (start of a new transfer)
//   shift_en       in   accept bit_in this cycle
//   bit_in         in   serial data bit
//   word           out  assembled word including bit_in (valid with word_complete)
//   word_complete  out  this cycle's accepted bit finishes a word
//
//  data_len must be at least 2.
module master_rx_shift #(
  parameter int data_len = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift_en,
  input  logic                bit_in,
  output logic [data_len-1:0] word,
  output logic                word_complete
);

  localparam int CNT_W = (data_len > 1) ? $clog2(data_len) : 1;

  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [data_len-1:0] shift_reg;
  logic [data_len-1:0] shift_next;
  logic                last_bit;

  assign last_bit = (bit_cnt_reg == CNT_W'(data_len - 1));

  always_comb begin
`ifdef MASTER_IN_MSB_FIRST_EN
    // First bit ends up in the top position after data_len shifts.
    shift_next = {shift_reg[data_len-2:0], bit_in};
`else
    // First bit ends up in bit 0 after data_len shifts.
    shift_next = {bit_in, shift_reg[data_len-1:1]};
`endif
  end

  assign word          = shift_next;
  assign word_complete = shift_en && last_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (clear) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (shift_en) begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/master_in_port_rx.sv
// master_in_port_rx
//  Master-side receive port of the serial system bus. After the master
//  transmit port finishes a read request (tx_done), this block accepts
//  one word (single read) or burst_num words (burst read, 0 meaning 1)
//  from the slave over a ready/valid bit handshake, presents each
//  completed word on data with a one-cycle new_rx pulse, and pulses
//  rx_done with the final word.
//
//  Build option: define MASTER_IN_MSB_FIRST_EN to receive bits MSB
//  first; the default build receives LSB first. Timing is identical.
//
//  Ports
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   tx_done       in   request sent (1-cycle pulse)
//   instruction   in   request type, sampled with tx_done
//   burst_num     in   burst word count, sampled with tx_done
//   data          out  last complete received word (held)
//   rx_done       out  1-cycle pulse with the final word
//   new_rx        out  1-cycle pulse when data is updated
//   rx_data       in   serial data bit from slave
//   slave_valid   in   rx_data carries a valid bit
//   master_ready  out  port accepts bits (registered)
module master_in_port_rx
  import master_bus_pkg::*;
#(
  parameter int burst_len = 12,
  parameter int data_len  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_done,
  input  logic [1:0]           instruction,
  input  logic [burst_len-1:0] burst_num,
  output logic [data_len-1:0]  data,
  output logic                 rx_done,
  output logic                 new_rx,
  input  logic                 rx_data,
  input  logic                 slave_valid,
  output logic                 master_ready
);

  rx_state_t state_reg, state_next;

  logic [burst_len-1:0] word_cnt_reg;
  logic [burst_len-1:0] word_total_reg;
  logic [data_len-1:0]  data_reg;
  logic                 rx_done_reg;
  logic                 new_rx_reg;
  logic                 master_ready_reg;

  logic                 start;
  logic                 accept;
  logic                 final_word;
  logic [data_len-1:0]  shift_word;
  logic                 word_complete;

  // master_ready is only ever high in RX, so it alone qualifies a bit.
  assign accept = master_ready_reg && slave_valid;

  master_rx_shift #(
    .data_len (data_len)
  ) u_shift (
    .clk           (clk),
    .reset         (reset),
    .clear         (start),
    .shift_en      (accept),
    .bit_in        (rx_data),
    .word          (shift_word),
    .word_complete (word_complete)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. tx_done is only looked at in IDLE, so a stray
  // request during a transfer cannot disturb it.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    final_word = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tx_done && is_read(instruction)) begin
          start      = 1'b1;
          state_next = ST_RX;
        end
      end
      ST_RX: begin
        if (word_complete && (word_cnt_reg == word_total_reg - burst_len'(1))) begin
          final_word = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Word bookkeeping and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_reg     <= '0;
      word_total_reg   <= '0;
      data_reg         <= '0;
      rx_done_reg      <= 1'b0;
      new_rx_reg       <= 1'b0;
      master_ready_reg <= 1'b0;
    end else begin
      new_rx_reg  <= word_complete;
      rx_done_reg <= final_word;
      if (start) begin
        word_cnt_reg     <= '0;
        master_ready_reg <= 1'b1;
        // A burst of zero words still returns one word.
        if ((instruction == INSTR_RD_SINGLE) || (burst_num == '0)) begin
          word_total_reg <= burst_len'(1);
        end else begin
          word_total_reg <= burst_num;
        end
      end
      if (word_complete) begin
        data_reg     <= shift_word;
        word_cnt_reg <= word_cnt_reg + burst_len'(1);
      end
      if (final_word) begin
        master_ready_reg <= 1'b0;
      end
    end
  end

  assign data         = data_reg;
  assign rx_done      = rx_done_reg;
  assign new_rx       = new_rx_reg;
  assign master_ready = master_ready_reg;

endmodule

// File: tb/tb_master_in_port_rx.sv
module tb_master_in_port_rx;

  localparam int BL = 12;
  localparam int DL = 8;

  logic          clk         = 1'b0;
  logic          reset       = 1'b0;
  logic          tx_done     = 1'b0;
  logic [1:0]    instruction = 2'b00;
  logic [BL-1:0] burst_num   = '0;
  logic          rx_data     = 1'b0;
  logic          slave_valid = 1'b0;
  logic [DL-1:0] data;
  logic          rx_done;
  logic          new_rx;
  logic          master_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DL-1:0] word;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  master_in_port_rx #(
    .burst_len (BL),
    .data_len  (DL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_done      (tx_done),
    .instruction  (instruction),
    .burst_num    (burst_num),
    .data         (data),
    .rx_done      (rx_done),
    .new_rx       (new_rx),
    .rx_data      (rx_data),
    .slave_valid  (slave_valid),
    .master_ready (master_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every new_rx pops one expected word.
  always @(negedge clk) begin
    if (new_rx === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word data=%h rx_done=%b", data, rx_done);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (data !== mon_e.word) begin
          bad++;
          $display("FAIL word_data got=%h exp=%h", data, mon_e.word);
        end else begin
          $display("word ok data=%h last=%b", data, mon_e.last);
        end
        total++;
        if (rx_done !== mon_e.last) begin
          bad++;
          $display("FAIL word_rx_done got=%b exp=%b data=%h", rx_done, mon_e.last, data);
        end
      end
    end else if (rx_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL rx_done_without_new_rx");
    end
  end

  task automatic push_exp(input logic [DL-1:0] w, input logic last);
    exp_t e;
    e.word = w;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_req(input logic [1:0] instr, input logic [BL-1:0] bn);
    tx_done     = 1'b1;
    instruction = instr;
    burst_num   = bn;
    @(posedge clk); #1;
    tx_done     = 1'b0;
  endtask

  function automatic int bit_index(input int i);
`ifdef MASTER_IN_MSB_FIRST_EN
    return DL - 1 - i;
`else
    return i;
`endif
  endfunction

  // Sends one word; every accepted bit is checked against master_ready.
  task automatic send_word(input logic [DL-1:0] w, input bit gapped);
    for (int i = 0; i < DL; i++) begin
      rx_data     = w[bit_index(i)];
      slave_valid = 1'b1;
      total++;
      if (master_ready !== 1'b1) begin
        bad++;
        $display("FAIL ready_during_word got=%b exp=1 word=%h bit=%0d", master_ready, w, i);
      end
      @(posedge clk); #1;
      if (gapped && i < DL - 1) begin
        slave_valid = 1'b0;
        rx_data     = ~w[bit_index(i)];
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    slave_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    total++;
    if (master_ready !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, master_ready, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (data !== '0 || rx_done !== 1'b0 || new_rx !== 1'b0 || master_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs data=%h rx_done=%b new_rx=%b ready=%b exp all 0",
               data, rx_done, new_rx, master_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_ready("reset_idle_ready", 1'b0);
  endtask

  task automatic test_single();
    push_exp(8'hA5, 1'b1);
    start_req(2'b00, '0);
    check_ready("single_ready_up", 1'b1);
    send_word(8'hA5, 1'b0);
    check_ready("single_ready_drop", 1'b0);
    // Slave bits after the transfer must be ignored.
    for (int i = 0; i < 10; i++) begin
      rx_data     = i[0];
      slave_valid = 1'b1;
      @(posedge clk); #1;
    end
    drain("single");
    total++;
    if (data !== 8'hA5) begin
      bad++;
      $display("FAIL single_data_hold got=%h exp=a5", data);
    end
  endtask

  task automatic test_burst();
    push_exp(8'h11, 1'b0);
    push_exp(8'h22, 1'b0);
    push_exp(8'h33, 1'b1);
    start_req(2'b01, 12'd3);
    send_word(8'h11, 1'b0);
    // A new request during the transfer must be ignored.
    tx_done     = 1'b1;
    instruction = 2'b01;
    burst_num   = 12'd5;
    send_word(8'h22, 1'b0);
    tx_done     = 1'b0;
    send_word(8'h33, 1'b0);
    check_ready("burst_ready_drop", 1'b0);
    drain("burst");
  endtask

  task automatic test_gapped();
    push_exp(8'h5A, 1'b1);
    start_req(2'b00, '0);
    send_word(8'h5A, 1'b1);
    check_ready("gapped_ready_drop", 1'b0);
    drain("gapped");
  endtask

  task automatic test_write();
    logic [1:0] wi;
    for (int k = 0; k < 2; k++) begin
      wi = (k == 0) ? 2'b10 : 2'b11;
      start_req(wi, 12'd4);
      for (int i = 0; i < 10; i++) begin
        rx_data     = i[0];
        slave_valid = 1'b1;
        check_ready("write_ready_low", 1'b0);
        @(posedge clk); #1;
      end
      slave_valid = 1'b0;
    end
    drain("write");
  endtask

  task automatic test_reset_mid();
    logic [DL-1:0] w;
    w = 8'hC3;
    start_req(2'b00, '0);
    for (int i = 0; i < 4; i++) begin
      rx_data     = w[bit_index(i)];
      slave_valid = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    total++;
    if (data !== '0 || rx_done !== 1'b0 || new_rx !== 1'b0 || master_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs data=%h rx_done=%b new_rx=%b ready=%b exp all 0",
               data, rx_done, new_rx, master_ready);
    end
    slave_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_exp(8'h3C, 1'b1);
    start_req(2'b00, '0);
    send_word(8'h3C, 1'b0);
    drain("after_reset");
  endtask

  task automatic test_burst_zero();
    push_exp(8'h96, 1'b1);
    start_req(2'b01, '0);
    send_word(8'h96, 1'b0);
    check_ready("burst0_ready_drop", 1'b0);
    for (int i = 0; i < DL; i++) begin
      rx_data     = i[1];
      slave_valid = 1'b1;
      @(posedge clk); #1;
    end
    drain("burst0");
  endtask

  task automatic test_back_to_back_random();
    logic [DL-1:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = DL'($urandom_range(0, 255));
      push_exp(w[i], (i == 3) ? 1'b1 : 1'b0);
    end
    start_req(2'b01, 12'd4);
    for (int i = 0; i < 4; i++) begin
      send_word(w[i], i[0]);
    end
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_gapped();
    test_write();
    test_reset_mid();
    test_burst_zero();
    test_back_to_back_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
